// File: rtl/divider_iter_pkg.sv
// Shared constants and types for the iterative radix-2 restoring divider.
// Also holds the small helper that applies the remainder sign.
package divider_iter_pkg;

    localparam int DIV_W = 32;
    localparam int CNT_W = 6;

    // Counter value at which the final quotient bit is produced
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_W - 1);

    // Divide-by-zero quotients; the converter negates the signed case to -1
    localparam logic [DIV_W-1:0] DZ_Q_POS = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] DZ_Q_NEG = DIV_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    function automatic logic [DIV_W-1:0] apply_sign(
        input logic [DIV_W-1:0] mag,
        input logic             neg
    );
        return neg ? (~mag + DIV_W'(1)) : mag;
    endfunction

endpackage

// File: rtl/divider_iter_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract
// the divisor, keep the difference and set the quotient bit when it fits.
module divider_iter_div_step
    import divider_iter_pkg::*;
(
    input  logic [DIV_W:0]   rem,
    input  logic [DIV_W-1:0] quo,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W:0]   rem_next,
    output logic [DIV_W-1:0] quo_next
);

    logic [DIV_W:0]   shifted;
    logic [DIV_W+1:0] trial;
    logic             trial_neg;
    logic             unused_rem_msb;

    // The partial remainder always stays below the divisor, so its top bit
    // is zero on entry and shifts out harmlessly.
    assign unused_rem_msb = rem[DIV_W];

    assign shifted   = {rem[DIV_W-1:0], quo[DIV_W-1]};
    assign trial     = {1'b0, shifted} - {2'b00, divisor};
    assign trial_neg = trial[DIV_W+1];

    assign rem_next = trial_neg ? shifted : trial[DIV_W:0];
    assign quo_next = {quo[DIV_W-2:0], ~trial_neg};

endmodule

// File: rtl/divider_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, unsigned
// quotient magnitude out, remainder with the dividend sign applied.
module divider_iter
    import divider_iter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    input  logic             dividend_neg,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] divider_q_o,
    output logic [DIV_W-1:0] divider_r_o
);

    div_state_t        state_reg, state_next;
    logic [DIV_W:0]    rem_reg;
    logic [DIV_W-1:0]  quo_reg;
    logic [DIV_W-1:0]  divisor_reg;
    logic              neg_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [DIV_W-1:0]  q_reg;
    logic [DIV_W-1:0]  r_reg;

    logic [DIV_W:0]    rem_step;
    logic [DIV_W-1:0]  quo_step;
    logic              accept;
    logic              load_result;
    logic [DIV_W-1:0]  res_q;
    logic [DIV_W-1:0]  res_r;

    divider_iter_div_step u_div_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (divisor_reg),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // Results are captured on the edge that enters DONE, so they are
    // already valid during the done cycle.
    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        load_result = 1'b0;
        res_q       = q_reg;
        res_r       = r_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start && !flush) begin
                    accept = 1'b1;
                    if (divisor == '0) begin
                        state_next  = ST_DONE;
                        load_result = 1'b1;
                        res_q       = dividend_neg ? DZ_Q_NEG : DZ_Q_POS;
                        res_r       = apply_sign(dividend, dividend_neg);
                    end else begin
                        state_next = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (count_reg == LAST_STEP) begin
                    state_next  = ST_DONE;
                    load_result = 1'b1;
                    res_q       = quo_step;
                    res_r       = apply_sign(rem_step[DIV_W-1:0], neg_reg);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            neg_reg     <= 1'b0;
            count_reg   <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                divisor_reg <= divisor;
                neg_reg     <= dividend_neg;
                rem_reg     <= '0;
                quo_reg     <= dividend;
                count_reg   <= '0;
            end else if (state_reg == ST_CALC && !flush) begin
                rem_reg   <= rem_step;
                quo_reg   <= quo_step;
                count_reg <= count_reg + CNT_W'(1);
            end
            if (load_result) begin
                q_reg <= res_q;
                r_reg <= res_r;
            end
        end
    end

    assign busy        = (state_reg != ST_IDLE);
    assign done        = (state_reg == ST_DONE);
    assign divider_q_o = q_reg;
    assign divider_r_o = r_reg;

endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter: directed cases plus random operands
// compared against plain-arithmetic division results.
module tb_divider_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        dividend_neg;
    logic        busy;
    logic        done;
    logic [31:0] divider_q_o;
    logic [31:0] divider_r_o;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    divider_iter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .flush        (flush),
        .dividend     (dividend),
        .divisor      (divisor),
        .dividend_neg (dividend_neg),
        .busy         (busy),
        .done         (done),
        .divider_q_o  (divider_q_o),
        .divider_r_o  (divider_r_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b,
                                          input logic neg);
        if (b == 32'd0) return neg ? 32'd1 : 32'hFFFF_FFFF;
        return a / b;
    endfunction

    function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b,
                                          input logic neg);
        logic [31:0] m;
        m = (b == 32'd0) ? a : (a % b);
        return neg ? (32'd0 - m) : m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic neg);
        dividend     = a;
        divisor      = b;
        dividend_neg = neg;
        start        = 1'b1;
        cyc          = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit busy_ok);
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 80) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic neg);
        logic [31:0] eq, er;
        int          lat;
        bit          busy_ok;
        eq  = ref_q(a, b, neg);
        er  = ref_r(a, b, neg);
        lat = (b == 32'd0) ? 1 : 33;
        launch(a, b, neg);
        wait_done(busy_ok);
        check({name, ".busy_calc"}, 32'(busy_ok), 32'd1);
        check({name, ".latency"}, 32'(cyc), 32'(lat));
        check({name, ".busy_done"}, 32'(busy), 32'd1);
        check({name, ".q"}, divider_q_o, eq);
        check({name, ".r"}, divider_r_o, er);
        $display("op %s: %h / %h neg=%0d -> q=%h r=%h done at cycle %0d",
                 name, a, b, neg, divider_q_o, divider_r_o, cyc);
        tick();
        check({name, ".done_pulse"}, 32'(done), 32'd0);
        check({name, ".idle_after"}, 32'(busy), 32'd0);
        check({name, ".q_hold"}, divider_q_o, eq);
        check({name, ".r_hold"}, divider_r_o, er);
    endtask

    initial begin
        logic [31:0] a, b, hold_q, hold_r;
        logic        neg;
        bit          busy_ok, saw_done;
        int          mode;

        rst_n        = 1'b0;
        start        = 1'b0;
        flush        = 1'b0;
        dividend     = '0;
        divisor      = '0;
        dividend_neg = 1'b0;
        tick();
        tick();
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.q", divider_q_o, 32'd0);
        check("reset.r", divider_r_o, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("d100_7", 32'd100, 32'd7, 1'b0);
        run_op("max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("d5_9", 32'd5, 32'd9, 1'b0);
        run_op("neg7_2", 32'd7, 32'd2, 1'b1);
        run_op("dz_pos", 32'h0000_1234, 32'd0, 1'b0);
        run_op("dz_neg", 32'd5, 32'd0, 1'b1);
        run_op("ovf", 32'h8000_0000, 32'd1, 1'b1);
        run_op("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Flush in the middle of CALC: no done, outputs keep the prior result
        hold_q = divider_q_o;
        hold_r = divider_r_o;
        launch(32'd1000, 32'd3, 1'b0);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush.busy", 32'(busy), 32'd0);
        check("flush.done", 32'(done), 32'd0);
        check("flush.q", divider_q_o, hold_q);
        check("flush.r", divider_r_o, hold_r);
        saw_done = 1'b0;
        repeat (40) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        check("flush.no_done", 32'(saw_done), 32'd0);
        $display("op flush: 1000 / 3 aborted at cycle 10, outputs held q=%h r=%h",
                 divider_q_o, divider_r_o);

        // Flush together with start in IDLE: nothing launches
        dividend = 32'd9;
        divisor  = 32'd2;
        start    = 1'b1;
        flush    = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush_start.busy", 32'(busy), 32'd0);
        $display("op flush+start: ignored, busy=%0d", busy);

        // A second start during CALC is ignored and not queued
        launch(32'd1000, 32'd7, 1'b0);
        repeat (4) tick();
        dividend = 32'd77;
        divisor  = 32'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_done(busy_ok);
        check("ign_start.latency", 32'(cyc), 32'd33);
        check("ign_start.q", divider_q_o, 32'd142);
        check("ign_start.r", divider_r_o, 32'd6);
        tick();
        saw_done = 1'b0;
        repeat (40) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            tick();
        end
        check("ign_start.no_queue", 32'(saw_done), 32'd0);
        $display("op ignored start: 1000 / 7 -> q=%h r=%h", divider_q_o, divider_r_o);

        // Reset in the middle of CALC discards the operation
        launch(32'd999, 32'd10, 1'b1);
        repeat (14) tick();
        rst_n = 1'b0;
        tick();
        check("rst_mid.busy", 32'(busy), 32'd0);
        check("rst_mid.done", 32'(done), 32'd0);
        check("rst_mid.q", divider_q_o, 32'd0);
        check("rst_mid.r", divider_r_o, 32'd0);
        rst_n = 1'b1;
        tick();
        $display("op reset mid-CALC: outputs cleared");
        run_op("after_rst", 32'd999, 32'd10, 1'b1);

        for (int i = 0; i < 20; i++) begin
            mode = int'($urandom_range(0, 3));
            a    = $urandom;
            if ($urandom_range(0, 1) == 1) a = a >> $urandom_range(0, 31);
            case (mode)
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            neg = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), a, b, neg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
